// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing a simple dual-port block RAM (A = write, B = read) among NUM_REQ requesters.
// Define ARB_LOCK_EN to let a granted requester hold the pointer with its lock bit for bursts.
module ram_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 10,
    parameter int DW      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]    lock,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DW-1:0]         rdata,
    output logic                  ena,
    output logic                  wea,
    output logic [AW-1:0]         addra,
    output logic [DW-1:0]         dia,
    output logic                  enb,
    output logic [AW-1:0]         addrb,
    input  logic [DW-1:0]         dob
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [AW-1:0] addr_arr [NUM_REQ];
    logic [DW-1:0] data_arr [NUM_REQ];

    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               ena_q, ena_d, wea_q, wea_d, enb_q, enb_d;
    logic [AW-1:0]      addra_q, addra_d, addrb_q, addrb_d;
    logic [DW-1:0]      dia_q, dia_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      gid_q, gid_d;
    logic               rd_pend_q, rd_pend_d;
    logic [IW-1:0]      rd_id_q, rd_id_d;

    logic               found;
    logic [IW-1:0]      win;
    logic [IW-1:0]      rr_nxt;
    int                 cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign addr_arr[g] = req_addr[g*AW +: AW];
        assign data_arr[g] = req_wdata[g*DW +: DW];
        assign rvalid[g]   = rd_pend_q && (int'(rd_id_q) == g);
    end

`ifndef ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // First set request at or after rr_ptr, wrapping at NUM_REQ-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req[IW'(cand)]) begin
                found = 1'b1;
                win   = IW'(cand);
            end
        end
        rr_nxt = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
    end

    always_comb begin
        gnt_d    = '0;
        ena_d    = 1'b0;
        wea_d    = 1'b0;
        enb_d    = 1'b0;
        addra_d  = addra_q;
        addrb_d  = addrb_q;
        dia_d    = dia_q;
        rr_ptr_d = rr_ptr_q;
        gid_d    = gid_q;
        // dob becomes valid one edge after enb, so the return tracks enb by one cycle
        rd_pend_d = enb_q;
        rd_id_d   = enb_q ? gid_q : rd_id_q;
        if (found) begin
            gnt_d[win] = 1'b1;
            gid_d      = win;
            rr_ptr_d   = rr_nxt;
`ifdef ARB_LOCK_EN
            if (lock[win]) rr_ptr_d = win;
`endif
            if (req_we[win]) begin
                ena_d   = 1'b1;
                wea_d   = 1'b1;
                addra_d = addr_arr[win];
                dia_d   = data_arr[win];
            end else begin
                enb_d   = 1'b1;
                addrb_d = addr_arr[win];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q     <= '0;
            ena_q     <= 1'b0;
            wea_q     <= 1'b0;
            enb_q     <= 1'b0;
            addra_q   <= '0;
            addrb_q   <= '0;
            dia_q     <= '0;
            rr_ptr_q  <= '0;
            gid_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
        end else begin
            gnt_q     <= gnt_d;
            ena_q     <= ena_d;
            wea_q     <= wea_d;
            enb_q     <= enb_d;
            addra_q   <= addra_d;
            addrb_q   <= addrb_d;
            dia_q     <= dia_d;
            rr_ptr_q  <= rr_ptr_d;
            gid_q     <= gid_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    assign gnt   = gnt_q;
    assign ena   = ena_q;
    assign wea   = wea_q;
    assign enb   = enb_q;
    assign addra = addra_q;
    assign addrb = addrb_q;
    assign dia   = dia_q;
    assign rdata = dob;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural simple dual-port RAM behind it.
module tb_ram_port_arbiter;
    localparam int NR = 3;
    localparam int AW = 10;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        req, req_we, lock, gnt, rvalid;
    logic [NR*AW-1:0]     req_addr;
    logic [NR*DW-1:0]     req_wdata;
    logic [DW-1:0]        rdata, dia, dob;
    logic                 ena, wea, enb;
    logic [AW-1:0]        addra, addrb;
    logic [DW-1:0]        mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .lock(lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ena(ena), .wea(wea), .addra(addra), .dia(dia), .enb(enb), .addrb(addrb), .dob(dob)
    );

    always @(posedge clk) begin
        if (ena && wea) mem[addra] <= dia;
        if (enb) dob <= mem[addrb];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
        req[i]                 = 1'b1;
    endtask

    logic [DW-1:0] rd_exp [3];

    initial begin
        rst = 1'b1; req = '0; req_we = '0; lock = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
        rd_exp[0] = 8'h11; rd_exp[1] = 8'h22; rd_exp[2] = 8'h33;

        // reset then idle
        tick; tick;
        rst = 1'b0;
        tick; tick; tick;
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_ena", ena, 0);
        chk("rst_wea", wea, 0);
        chk("rst_enb", enb, 0);
        chk("rst_addra", addra, 0);
        chk("rst_addrb", addrb, 0);
        chk("rst_dia", dia, 0);

        // requester 1 writes 0x5A to 0x010 then reads it back
        set_req(1, 1'b1, 10'h010, 8'h5A);
        tick;
        chk("wr_gnt", gnt, 3'b010);
        chk("wr_ena", ena, 1);
        chk("wr_wea", wea, 1);
        chk("wr_addra", addra, 10'h010);
        chk("wr_dia", dia, 8'h5A);
        chk("wr_enb", enb, 0);
        req = '0;
        tick;
        chk("idle_gnt", gnt, 0);
        chk("idle_ena", ena, 0);
        chk("idle_addra_hold", addra, 10'h010);
        chk("idle_dia_hold", dia, 8'h5A);
        set_req(1, 1'b0, 10'h010, 8'h00);
        tick;
        chk("rd_gnt", gnt, 3'b010);
        chk("rd_enb", enb, 1);
        chk("rd_addrb", addrb, 10'h010);
        chk("rd_ena", ena, 0);
        chk("rd_rvalid_early", rvalid, 0);
        req = '0;
        tick;
        chk("rd_rvalid", rvalid, 3'b010);
        chk("rd_rdata", rdata, 8'h5A);
        chk("rd_enb_off", enb, 0);
        tick;
        chk("rd_rvalid_pulse", rvalid, 0);
        chk("rd_addrb_hold", addrb, 10'h010);

        // all three read continuously from a fresh pointer
        rst = 1'b1; tick; rst = 1'b0;
        set_req(0, 1'b0, 10'h001, 8'h00);
        set_req(1, 1'b0, 10'h002, 8'h00);
        set_req(2, 1'b0, 10'h003, 8'h00);
        for (int k = 0; k < 6; k++) begin
            tick;
            chk($sformatf("rr_gnt%0d", k), gnt, 32'(1 << (k % 3)));
            chk($sformatf("rr_addrb%0d", k), addrb, 32'((k % 3) + 1));
            if (k >= 1) begin
                chk($sformatf("rr_rvalid%0d", k), rvalid, 32'(1 << ((k - 1) % 3)));
                chk($sformatf("rr_rdata%0d", k), rdata, rd_exp[(k - 1) % 3]);
            end
        end
        req = '0;
        tick;
        chk("rr_gnt_end", gnt, 0);
        chk("rr_rvalid_end", rvalid, 3'b100);
        chk("rr_rdata_end", rdata, 8'h33);
        tick;

        // write by 0 then read by 2 on the same address, back to back
        set_req(0, 1'b1, 10'h020, 8'h77);
        set_req(2, 1'b0, 10'h020, 8'h00);
        tick;
        chk("raw_gnt_w", gnt, 3'b001);
        chk("raw_wea", wea, 1);
        req[0] = 1'b0;
        tick;
        chk("raw_gnt_r", gnt, 3'b100);
        chk("raw_enb", enb, 1);
        req[2] = 1'b0;
        tick;
        chk("raw_rvalid", rvalid, 3'b100);
        chk("raw_rdata", rdata, 8'h77);
        tick;

        // reset right behind a read grant discards the return
        set_req(1, 1'b0, 10'h001, 8'h00);
        tick;
        chk("rrst_gnt", gnt, 3'b010);
        req = '0;
        rst = 1'b1;
        tick;
        chk("rrst_rvalid", rvalid, 0);
        chk("rrst_enb", enb, 0);
        chk("rrst_gnt_off", gnt, 0);
        rst = 1'b0;
        tick;
        chk("rrst_rvalid2", rvalid, 0);
        set_req(1, 1'b0, 10'h002, 8'h00);
        set_req(2, 1'b0, 10'h003, 8'h00);
        tick;
        chk("rrst_ptr0", gnt, 3'b010);
        req = '0;
        tick; tick;

        // requester 0 with lock against requester 1
        set_req(0, 1'b0, 10'h001, 8'h00);
        set_req(1, 1'b0, 10'h002, 8'h00);
        lock[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
`ifdef ARB_LOCK_EN
            chk($sformatf("lock_gnt%0d", k), gnt, 3'b001);
`else
            chk($sformatf("lock_gnt%0d", k), gnt, (k % 2 == 0) ? 3'b001 : 3'b010);
`endif
        end
        req[0] = 1'b0;
        lock[0] = 1'b0;
        tick;
        chk("lock_release", gnt, 3'b010);
        req = '0;
        tick; tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
